// File: rtl/lerp2_sweep.sv
// Raster sequencer feeding lerp2: one lerp2 evaluation per sample of an X x Y cell.
// LERP2_SWEEP_CORNER_BYPASS_EN: sample (0,0) returns p0 directly without lerp2.
module lerp2_sweep #(
  parameter int WIDTH = 32,
  parameter int FBITS = 16,
  parameter int CW    = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_p0,
  input  logic [WIDTH-1:0] cmd_p1,
  input  logic [WIDTH-1:0] cmd_p2,
  input  logic [WIDTH-1:0] cmd_p3,
  input  logic [CW-1:0]    cmd_X,
  input  logic [CW-1:0]    cmd_Y,
  output logic [WIDTH-1:0] lerp_p0,
  output logic [WIDTH-1:0] lerp_p1,
  output logic [WIDTH-1:0] lerp_p2,
  output logic [WIDTH-1:0] lerp_p3,
  output logic [WIDTH-1:0] lerp_x,
  output logic [WIDTH-1:0] lerp_y,
  output logic [WIDTH-1:0] lerp_X,
  output logic [WIDTH-1:0] lerp_Y,
  output logic             lerp_start,
  input  logic             lerp_done,
  input  logic             lerp_error,
  input  logic [WIDTH-1:0] lerp_val,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_val,
  output logic [CW-1:0]    out_x,
  output logic [CW-1:0]    out_y,
  output logic             out_last,
  output logic             busy,
  output logic             error
);

  typedef enum logic [1:0] {
    IDLE, ISSUE, WAIT, OUT
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] p0_q, p0_d, p1_q, p1_d;
  logic [WIDTH-1:0] p2_q, p2_d, p3_q, p3_d;
  logic [WIDTH-1:0] val_q, val_d;
  logic [CW-1:0]    cx_q, cx_d, cy_q, cy_d;
  logic [CW-1:0]    ix_q, ix_d, iy_q, iy_d;
  logic             err_q, err_d;

  logic end_x, end_y, last_w;

  assign end_x  = (ix_q == cx_q - CW'(1));
  assign end_y  = (iy_q == cy_q - CW'(1));
  assign last_w = end_x && end_y;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      p0_q    <= '0;
      p1_q    <= '0;
      p2_q    <= '0;
      p3_q    <= '0;
      val_q   <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      ix_q    <= '0;
      iy_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      p0_q    <= p0_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      p3_q    <= p3_d;
      val_q   <= val_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      ix_q    <= ix_d;
      iy_q    <= iy_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    p0_d    = p0_q;
    p1_d    = p1_q;
    p2_d    = p2_q;
    p3_d    = p3_q;
    val_d   = val_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    ix_d    = ix_q;
    iy_d    = iy_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          p0_d = cmd_p0;
          p1_d = cmd_p1;
          p2_d = cmd_p2;
          p3_d = cmd_p3;
          cx_d = cmd_X;
          cy_d = cmd_Y;
          if (cmd_X == '0 || cmd_Y == '0) begin
            err_d = 1'b1;
          end else begin
            ix_d = '0;
            iy_d = '0;
`ifdef LERP2_SWEEP_CORNER_BYPASS_EN
            val_d   = cmd_p0;
            state_d = OUT;
`else
            state_d = ISSUE;
`endif
          end
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (lerp_done) begin
          if (lerp_error) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            val_d   = lerp_val;
            state_d = OUT;
          end
        end
      end
      OUT: begin
        if (out_ready) begin
          if (last_w) begin
            state_d = IDLE;
          end else begin
            if (end_x) begin
              ix_d = '0;
              iy_d = iy_q + CW'(1);
            end else begin
              ix_d = ix_q + CW'(1);
            end
            state_d = ISSUE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready  = (state_q == IDLE);
    busy       = (state_q != IDLE);
    lerp_start = (state_q == ISSUE);
    out_valid  = (state_q == OUT);
    out_last   = (state_q == OUT) && last_w;
    error      = err_q;
    out_val    = val_q;
    out_x      = ix_q;
    out_y      = iy_q;
    lerp_p0    = p0_q;
    lerp_p1    = p1_q;
    lerp_p2    = p2_q;
    lerp_p3    = p3_q;
    // zero-extended integer indices moved into fixed point
    lerp_x     = WIDTH'(ix_q) << FBITS;
    lerp_y     = WIDTH'(iy_q) << FBITS;
    lerp_X     = WIDTH'(cx_q) << FBITS;
    lerp_Y     = WIDTH'(cy_q) << FBITS;
  end

endmodule

// File: tb/tb_lerp2_sweep.sv
// Directed bench for lerp2_sweep with a behavioural bilinear lerp2 stand-in.
// Covers sweep order, backpressure, bad command, lerp2 error and mid-cell reset.
module tb_lerp2_sweep;

  localparam int WIDTH = 32;
  localparam int FBITS = 16;
  localparam int CW    = 8;

  logic             clock = 1'b0;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_p0, cmd_p1, cmd_p2, cmd_p3;
  logic [CW-1:0]    cmd_X, cmd_Y;
  logic [WIDTH-1:0] lerp_p0, lerp_p1, lerp_p2, lerp_p3;
  logic [WIDTH-1:0] lerp_x, lerp_y, lerp_X, lerp_Y;
  logic             lerp_start;
  logic             lerp_done;
  logic             lerp_error;
  logic [WIDTH-1:0] lerp_val;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_val;
  logic [CW-1:0]    out_x, out_y;
  logic             out_last;
  logic             busy;
  logic             error;

  lerp2_sweep #(.WIDTH(WIDTH), .FBITS(FBITS), .CW(CW)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_p0(cmd_p0), .cmd_p1(cmd_p1), .cmd_p2(cmd_p2), .cmd_p3(cmd_p3),
    .cmd_X(cmd_X), .cmd_Y(cmd_Y),
    .lerp_p0(lerp_p0), .lerp_p1(lerp_p1),
    .lerp_p2(lerp_p2), .lerp_p3(lerp_p3),
    .lerp_x(lerp_x), .lerp_y(lerp_y),
    .lerp_X(lerp_X), .lerp_Y(lerp_Y),
    .lerp_start(lerp_start), .lerp_done(lerp_done),
    .lerp_error(lerp_error), .lerp_val(lerp_val),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_val(out_val), .out_x(out_x), .out_y(out_y),
    .out_last(out_last), .busy(busy), .error(error)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [WIDTH-1:0] v;
    logic [CW-1:0]    x;
    logic [CW-1:0]    y;
    logic             l;
  } smp_t;

  smp_t q[$];
  int   starts = 0;
  int   errs   = 0;
  int   inj_at = 0;
  int   n_chk  = 0;
  int   n_fail = 0;

`ifdef LERP2_SWEEP_CORNER_BYPASS_EN
  localparam int STARTS_2X2 = 3;
  localparam int SECOND_ST  = 1;
`else
  localparam int STARTS_2X2 = 4;
  localparam int SECOND_ST  = 2;
`endif

  logic [WIDTH-1:0] ev [4] = '{32'h0, 32'h8000, 32'h10000, 32'h18000};
  logic [CW-1:0]    ex [4] = '{8'd0, 8'd1, 8'd0, 8'd1};
  logic [CW-1:0]    ey [4] = '{8'd0, 8'd0, 8'd1, 8'd1};

  // bilinear reference evaluated on integer sample coordinates
  function automatic logic [WIDTH-1:0] bilin();
    longint p0, p1, p2, p3, x, y, cx, cy, num;
    p0  = longint'($signed(lerp_p0));
    p1  = longint'($signed(lerp_p1));
    p2  = longint'($signed(lerp_p2));
    p3  = longint'($signed(lerp_p3));
    x   = longint'(lerp_x >> FBITS);
    y   = longint'(lerp_y >> FBITS);
    cx  = longint'(lerp_X >> FBITS);
    cy  = longint'(lerp_Y >> FBITS);
    num = p0 * (cx - x) * (cy - y) + p1 * x * (cy - y)
        + p2 * (cx - x) * y + p3 * x * y;
    return WIDTH'(num / (cx * cy));
  endfunction

  logic [2:0]       cnt;
  logic [WIDTH-1:0] res;
  logic             pend_err;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      res        <= '0;
      pend_err   <= 1'b0;
      lerp_done  <= 1'b0;
      lerp_error <= 1'b0;
      lerp_val   <= '0;
    end else begin
      lerp_done  <= 1'b0;
      lerp_error <= 1'b0;
      if (lerp_start) begin
        cnt      <= 3'd3;
        res      <= bilin();
        pend_err <= (inj_at != 0) && (starts + 1 == inj_at);
      end else if (cnt != 0) begin
        cnt <= cnt - 3'd1;
        if (cnt == 3'd1) begin
          lerp_done  <= 1'b1;
          lerp_error <= pend_err;
          lerp_val   <= res;
        end
      end
    end
  end

  always @(posedge clock) begin
    if (lerp_start) starts <= starts + 1;
    if (!reset && error) errs <= errs + 1;
    if (!reset && out_valid && out_ready)
      q.push_back('{out_val, out_x, out_y, out_last});
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [WIDTH-1:0] a, input logic [CW-1:0] x,
                      input logic [CW-1:0] y);
    @(negedge clock);
    cmd_p0    = a;
    cmd_p1    = 32'h10000;
    cmd_p2    = 32'h20000;
    cmd_p3    = 32'h30000;
    cmd_X     = x;
    cmd_Y     = y;
    cmd_valid = 1'b1;
    @(posedge clock);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (!busy) break;
    end
    chk(tag, busy, 0);
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (out_valid) break;
    end
    chk(tag, out_valid, 1);
  endtask

  task automatic chk_sweep(input string tag);
    chk({tag, "_n"}, q.size(), 4);
    for (int i = 0; i < 4 && i < q.size(); i++) begin
      chk($sformatf("%s_v%0d", tag, i), q[i].v, ev[i]);
      chk($sformatf("%s_xy%0d", tag, i), {q[i].x, q[i].y}, {ex[i], ey[i]});
      chk($sformatf("%s_l%0d", tag, i), q[i].l, i == 3);
    end
  endtask

  initial begin
    int st0, er0, sst;
    logic [WIDTH-1:0] sv;
    logic [CW-1:0]    sx, sy;
    logic             stable;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_p0    = '0;
    cmd_p1    = '0;
    cmd_p2    = '0;
    cmd_p3    = '0;
    cmd_X     = '0;
    cmd_Y     = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clock);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_oval", out_valid, 0);
    chk("rst_start", lerp_start, 0);
    chk("rst_err", error, 0);
    chk("rst_data", {out_val, out_x, out_y, out_last, lerp_X}, 0);
    reset = 1'b0;

    // basic 2x2 sweep
    st0 = starts;
    send(32'h0, 8'd2, 8'd2);
    wait_idle("basic_idle");
    chk_sweep("basic");
    chk("basic_starts", starts - st0, STARTS_2X2);
    q.delete();

    // backpressure on the second sample
    out_ready = 1'b0;
    send(32'h0, 8'd2, 8'd2);
    wait_valid("bp_v1");
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    wait_valid("bp_v2");
    sv     = out_val;
    sx     = out_x;
    sy     = out_y;
    sst    = starts;
    stable = 1'b1;
    repeat (5) begin
      @(negedge clock);
      if (out_val !== sv || out_x !== sx || out_y !== sy ||
          out_valid !== 1'b1 || out_last !== 1'b0)
        stable = 1'b0;
    end
    chk("bp_stable", stable, 1);
    chk("bp_nostart", starts - sst, 0);
    chk("bp_held", {sv, sx, sy}, {32'h8000, 8'd1, 8'd0});
    out_ready = 1'b1;
    wait_idle("bp_idle");
    chk_sweep("bp");
    q.delete();

    // zero-width command
    er0 = errs;
    send(32'h0, 8'd0, 8'd3);
    chk("bad_err", error, 1);
    chk("bad_busy", busy, 0);
    chk("bad_ready", cmd_ready, 1);
    @(posedge clock);
    #1 chk("bad_pulse", error, 0);
    repeat (4) @(negedge clock);
    chk("bad_noout", q.size(), 0);
    chk("bad_errcnt", errs - er0, 1);

    // lerp2 error on the second sample
    er0    = errs;
    inj_at = starts + SECOND_ST;
    send(32'h0, 8'd2, 8'd2);
    wait_idle("inj_idle");
    inj_at = 0;
    repeat (3) @(negedge clock);
    chk("inj_nout", q.size(), 1);
    chk("inj_errcnt", errs - er0, 1);
    chk("inj_ready", cmd_ready, 1);
    q.delete();

    // reset while waiting on lerp2
    send(32'h0, 8'd2, 8'd2);
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (lerp_start) break;
    end
    chk("rw_start", lerp_start, 1);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("rw_ready", cmd_ready, 1);
    chk("rw_busy", busy, 0);
    chk("rw_outs", {out_valid, out_val, out_x, out_y, out_last, error}, 0);
    chk("rw_lerp", {lerp_start, lerp_p1, lerp_X, lerp_Y}, 0);
    @(negedge clock);
    reset = 1'b0;
    q.delete();
    repeat (8) @(negedge clock);
    chk("rw_noout", q.size(), 0);
    send(32'h5000, 8'd1, 8'd1);
    wait_idle("rw_idle");
    chk("rw_n", q.size(), 1);
    if (q.size() > 0) begin
      chk("rw_val", q[0].v, 32'h5000);
      chk("rw_last", {q[0].l, q[0].x, q[0].y}, {1'b1, 8'd0, 8'd0});
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
